// File: rtl/dmem_mul_engine.sv
// Program-3 multiply sequencer: reads signed 16-bit operand pairs from data memory,
// multiplies them with a 16-cycle sign-magnitude shift-add, writes big-endian 32-bit products.
module dmem_mul_engine #(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    // state  | meaning
    // IDLE   | waiting for first start edge after reset
    // RD0-3  | fetch A_hi, A_lo, B_hi, B_lo of pair j
    // MUL    | 16 shift-add iterations on operand magnitudes
    // SIGN   | apply product sign, present MSB write
    // WR0-3  | write product bytes MSB first
    // NEXT   | advance pair index or finish
    // DONE   | run complete, done high until relaunch
    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_MUL, S_SIGN,
        S_WR0, S_WR1, S_WR2, S_WR3, S_NEXT, S_DONE
    } state_t;

    localparam int JW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    state_t        state;
    logic          start_q;
    logic [JW-1:0] j;
    logic [3:0]    cnt;
    logic [7:0]    a_hi, a_lo, b_hi;
    logic [15:0]   mcand;
    logic [31:0]   acc;
    logic [31:0]   p;

    logic          launch, last, neg;
    logic [AW-1:0] pair_off, src_addr, dst_addr;
    logic [15:0]   a_full, b_full, a_mag, b_mag;
    logic [16:0]   sum;
    logic [31:0]   p_next;

    assign pair_off = AW'({j, 2'b00});
    assign src_addr = AW'(SRC_BASE) + pair_off;
    assign dst_addr = AW'(DST_BASE) + pair_off;
    assign launch   = start & ~start_q & ((state == S_IDLE) | (state == S_DONE));
    assign last     = (j == JW'(NUM_PAIRS - 1));

    // b_lo is consumed straight off the read bus so the magnitude is ready on MUL entry
    assign a_full = {a_hi, a_lo};
    assign b_full = {b_hi, mem_rd_data};
    assign a_mag  = a_full[15] ? -a_full : a_full;
    assign b_mag  = b_full[15] ? -b_full : b_full;

    // acc holds {partial product, remaining multiplier bits}; both shift right together
    assign sum    = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, mcand} : 17'd0);
    assign neg    = a_hi[7] ^ b_hi[7];
    assign p_next = neg ? -acc : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'h00;
            j           <= '0;
            cnt         <= 4'd0;
            a_hi        <= 8'h00;
            a_lo        <= 8'h00;
            b_hi        <= 8'h00;
            mcand       <= 16'h0000;
            acc         <= 32'h0;
            p           <= 32'h0;
        end else begin
            start_q     <= start;
            mem_wr_en   <= 1'b0;
            mem_addr    <= AW'(DST_BASE);
            mem_wr_data <= 8'h00;
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        j        <= '0;
                        mem_addr <= AW'(SRC_BASE);
                        state    <= S_RD0;
                    end else if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                end
                S_RD0: begin
                    a_hi     <= mem_rd_data;
                    mem_addr <= src_addr + AW'(1);
                    state    <= S_RD1;
                end
                S_RD1: begin
                    a_lo     <= mem_rd_data;
                    mem_addr <= src_addr + AW'(2);
                    state    <= S_RD2;
                end
                S_RD2: begin
                    b_hi     <= mem_rd_data;
                    mem_addr <= src_addr + AW'(3);
                    state    <= S_RD3;
                end
                S_RD3: begin
                    mcand <= a_mag;
                    acc   <= {16'h0000, b_mag};
                    cnt   <= 4'd0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc <= {sum, acc[15:1]};
                    if (cnt == 4'd15) state <= S_SIGN;
                    else              cnt   <= cnt + 4'd1;
                end
                S_SIGN: begin
                    p           <= p_next;
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr;
                    mem_wr_data <= p_next[31:24];
                    state       <= S_WR0;
                end
                S_WR0: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr + AW'(1);
                    mem_wr_data <= p[23:16];
                    state       <= S_WR1;
                end
                S_WR1: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr + AW'(2);
                    mem_wr_data <= p[15:8];
                    state       <= S_WR2;
                end
                S_WR2: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= dst_addr + AW'(3);
                    mem_wr_data <= p[7:0];
                    state       <= S_WR3;
                end
                S_WR3: state <= S_NEXT;
                S_NEXT: begin
                    if (last) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        j        <= j + JW'(1);
                        mem_addr <= src_addr + AW'(4);
                        state    <= S_RD0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mul_engine.sv
// Scoreboard bench for dmem_mul_engine: expected writes queued at launch, monitor checks each strobe.
module tb_dmem_mul_engine;
    localparam int NP = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done, busy, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'h00, tb_data = 8'h00;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [15:0] opa [NP];
    logic [15:0] opb [NP];

    int checks = 0, errors = 0, wr_count = 0;

    dmem_mul_engine #(.NUM_PAIRS(NP), .SRC_BASE(0), .DST_BASE(64), .AW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en)  mem[mem_addr] <= mem_wr_data;
        else if (tb_we) mem[tb_addr]  <= tb_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%0d data=%h required none", mem_addr, mem_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wr_data), 32'(e.data));
                end
            end
        end
    endtask

    task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    task automatic load_ops();
        for (int k = 0; k < NP; k++) begin
            tb_write(8'(4*k),   opa[k][15:8]);
            tb_write(8'(4*k+1), opa[k][7:0]);
            tb_write(8'(4*k+2), opb[k][15:8]);
            tb_write(8'(4*k+3), opb[k][7:0]);
        end
        for (int k = 64; k < 128; k++) tb_write(8'(k), 8'hAA);
    endtask

    task automatic push_expected();
        logic signed [31:0] p;
        wr_t e;
        for (int k = 0; k < NP; k++) begin
            p = $signed(opa[k]) * $signed(opb[k]);
            for (int b = 0; b < 4; b++) begin
                e.addr = 8'(64 + 4*k + b);
                e.data = p[31-8*b -: 8];
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return {mem[64+4*k], mem[65+4*k], mem[66+4*k], mem[67+4*k]};
    endfunction

    task automatic check_untouched();
        int bad;
        bad = 0;
        for (int k = 0; k < NP; k++) begin
            if ({mem[4*k], mem[4*k+1]} !== opa[k]) bad++;
            if ({mem[4*k+2], mem[4*k+3]} !== opb[k]) bad++;
        end
        for (int k = 128; k < 256; k++) if (mem[k] !== pat(k)) bad++;
        chk("untouched", 32'(bad), 32'd0);
    endtask

    // toggle_at > 0: drop start after launch, raise it again at that cycle and hold through DONE
    task automatic run(input int toggle_at);
        int n;
        push_expected();
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!done && n < 600) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                chk("busy_after_launch", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
            if (toggle_at > 0 && n == toggle_at) start = 1'b1;
        end
        chk("done_latency", 32'(n), 32'd417);
        chk("wr_count", 32'(wr_count), 32'd64);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("no_relaunch_writes", 32'(wr_count), 32'd64);
        check_untouched();
        exp_q.delete();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 128; k < 256; k++) tb_write(8'(k), pat(k));

        // pair 0 = 3 * -2, rest zero
        for (int k = 0; k < NP; k++) begin opa[k] = 16'h0000; opb[k] = 16'h0000; end
        opa[0] = 16'h0003; opb[0] = 16'hFFFE;
        load_ops();
        run(0);
        chk("p_3x_m2", word(0), 32'hFFFFFFFA);
        chk("p_zero_pair", word(1), 32'h00000000);

        // sign/magnitude boundaries
        opa[0] = 16'h8000; opb[0] = 16'h8000;
        opa[1] = 16'h7FFF; opb[1] = 16'h8000;
        opa[2] = 16'h0000; opb[2] = 16'hFFFF;
        opa[3] = 16'hFFFF; opb[3] = 16'hFFFF;
        opa[4] = 16'h0123; opb[4] = 16'hFF00;
        load_ops();
        run(0);
        chk("p_min_min", word(0), 32'h40000000);
        chk("p_max_min", word(1), 32'hC0008000);
        chk("p_zero_neg", word(2), 32'h00000000);
        chk("p_m1_m1", word(3), 32'h00000001);
        chk("p_291_m256", word(4), 32'hFFFEDD00);

        // random runs with restart between
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < NP; k++) begin
                opa[k] = 16'($urandom);
                opb[k] = 16'($urandom);
            end
            load_ops();
            run(0);
        end

        // async reset mid-run, then relaunch
        for (int k = 0; k < NP; k++) begin opa[k] = 16'(k * 1111 - 9000); opb[k] = 16'(7 - k * 523); end
        load_ops();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 100) begin @(posedge clk); n++; end
        #2;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run(0);

        // start re-edge at cycle 50, held high through DONE
        run(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_mul_engine.md
Name: dmem_mul_engine

Overview:
- Hardware multiply sequencer for program 3 (double-precision two's-complement multiplication).
- Sits between the data memory and the program-3 checker: reads NUM_PAIRS signed 16-bit operand pairs from data memory bytes 0..63, multiplies each pair, and writes the signed 32-bit big-endian products to bytes 64..127.
- Raises done when every product is in memory.

Parameters:
NUM_PAIRS, 16, number of operand pairs processed per run
SRC_BASE, 0, byte address of first operand high byte
DST_BASE, 64, byte address of first product MSB
AW, 8, data-memory byte-address width

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  run request; a 0->1 transition launches a run
done  output  1  high from end of run until next launch or reset
busy  output  1  high while a run is in progress
mem_addr  output  AW  data-memory byte address
mem_rd_data  input  8  data-memory read byte, combinational from mem_addr
mem_wr_en  output  1  write strobe; memory writes on the clk edge
mem_wr_data  output  8  byte to write at mem_addr

Behaviour:
- Reset (reset=0, async): state=IDLE; done, busy, mem_wr_en = 0; mem_addr = 0; pair counter = 0; start edge register = 0. Reset mid-run abandons the run. Bytes already written stay in memory.
- Launch: start_q registers start. Launch occurs when start=1 && start_q=0 while in IDLE or DONE. On launch: done<=0, busy<=1, pair index j<=0, go to RD0.
- A start edge while busy is ignored. A held-high start never relaunches.
- Operand layout for pair j, big-endian:
  - A = {mem[SRC_BASE+4j], mem[SRC_BASE+4j+1]}
  - B = {mem[SRC_BASE+4j+2], mem[SRC_BASE+4j+3]}
  - Product P = A*B, signed 32-bit.
- States, one cycle each unless noted:
  - RD0..RD3: mem_addr = SRC_BASE+4j+k; latch mem_rd_data into A_hi, A_lo, B_hi, B_lo.
  - MUL (16 cycles): sign-magnitude shift-add.
    - Entry: |A| and |B| formed as 16-bit unsigned; -32768 maps to 0x8000.
    - Each cycle: if multiplier LSB is set, add multiplicand into a 33-bit accumulator; shift right one bit.
    - Iteration counter 0..15.
  - SIGN: P = (A[15]^B[15]) ? -mag : mag, truncated to 32 bits.
  - WR0..WR3: mem_wr_en=1, mem_addr = DST_BASE+4j+k, mem_wr_data = P[31:24], P[23:16], P[15:8], P[7:0] respectively.
  - NEXT: if j==NUM_PAIRS-1 go to DONE, else j<=j+1 and go to RD0.
  - DONE: busy=0, done=1, mem_wr_en=0; hold until launch or reset.
- Timing:
  - Each pair takes 4+16+1+4+1 = 26 cycles.
  - A full run (default) takes 416 cycles.
  - done first reads 1 at the 417th rising edge after the launch edge.
- mem_wr_en is 0 in every state except WR0..WR3.
- mem_addr is don't-care outside RDk/WRk; drive DST_BASE.
- Boundaries:
  - -32768*-32768 = 0x40000000 (fits, no overflow).
  - 0*x = 0 with no negative zero.
  - Address arithmetic never exceeds DST_BASE+4*NUM_PAIRS-1 = 127.
- Simultaneous events: reset low overrides everything. Launch and DONE exit in the same cycle: launch wins, done drops next edge.

Test Plan:
- Load pair 0 = A 3, B -2 (bytes 00 03 FF FE), pulse start -> mem[64..67] = FF FF FF FA (-6); done=1 after exactly 417 edges.
- Pairs {-32768,-32768}, {32767,-32768}, {0,-1}, {-1,-1} -> products 0x40000000, 0xC0008000 (-1073709056), 0x00000000, 0x00000001.
- 16 random signed pairs, 10 iterations with restart between runs -> all 16 products match a reference model; memory outside 64..127 untouched.
- Drop reset to 0 at cycle 100 of a run -> done=0, busy=0, mem_wr_en=0 immediately (async). Relaunch -> full correct result.
- Toggle start 0->1 at cycle 50 of a run, and hold start high through DONE -> no relaunch, cycle count unchanged, done stays 1.
- mem_wr_en monitor -> exactly 64 write strobes per run, addresses 64..127 in ascending order.
